// File: rtl/el2_trace_port_buf.sv
// el2_trace_port_buf: buffers retired-instruction trace packets in a small FIFO and
// serialises each one onto a 32-bit valid/ready port, headed by a drop-count/seq word.
module el2_trace_port_buf #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trace_en,
  input  logic [103:0]  trace_pkt,
  input  logic          tp_ready,
  output logic          tp_valid,
  output logic [31:0]   tp_data,
  output logic          tp_last,
  input  logic          overflow_clr,
  output logic          overflow,
  output logic [CW-1:0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 103;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    ADDR = 3'd2,
    INSN = 3'd3,
    TVAL = 3'd4
  } state_t;

  // Entry: insn[102:71] address[70:39] exception[38] ecause[37:33] interrupt[32] tval[31:0]
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [7:0]    seq_q, seq_d;
  logic          overflow_q, overflow_d;
  state_t        state_q, state_d;
  logic          tp_valid_q, tp_valid_d;
  logic          tp_last_q, tp_last_d;
  logic [31:0]   tp_data_q, tp_data_d;

  logic          pkt_valid_s, full_s, push_s, drop_s, pop_s, accept_s;
  logic          snap_s, done_s, has_tval_s;
  logic [EW-1:0] push_entry_s, head_s, next_head_s;

  function automatic logic [31:0] hdr_beat(input logic [EW-1:0] e,
                                           input logic [7:0]    drop,
                                           input logic [7:0]    sq);
    hdr_beat = {8'hA5, drop, e[38] | e[32], e[38], e[32], e[37:33], sq};
  endfunction

  // Push/drop qualification and FIFO head decode
  always_comb begin
    pkt_valid_s  = trace_pkt[39] & trace_en;
    full_s       = (count_q == CW'(DEPTH));
    push_s       = pkt_valid_s & ~full_s;
    drop_s       = pkt_valid_s & full_s;
    push_entry_s = {trace_pkt[103:40], trace_pkt[38:0]};
    head_s       = mem_q[rd_ptr_q];
    has_tval_s   = head_s[38] | head_s[32];
    accept_s     = tp_valid_q & tp_ready;
  end

  // Beat sequencer: next state and next registered beat
  always_comb begin
    state_d    = state_q;
    tp_valid_d = tp_valid_q;
    tp_data_d  = tp_data_q;
    tp_last_d  = tp_last_q;
    seq_d      = seq_q;
    pop_s      = 1'b0;
    snap_s     = 1'b0;
    done_s     = 1'b0;
    // A lone entry being replaced by a same-cycle push is not in memory yet
    next_head_s = (count_q == CW'(1)) ? push_entry_s : mem_q[rd_ptr_q + AW'(1)];
    case (state_q)
      IDLE: begin
        if (count_q != {CW{1'b0}}) begin
          state_d    = HDR;
          snap_s     = 1'b1;
          tp_valid_d = 1'b1;
          tp_data_d  = hdr_beat(head_s, drop_cnt_q, seq_q);
          tp_last_d  = 1'b0;
        end else begin
          tp_valid_d = 1'b0;
          tp_data_d  = 32'd0;
          tp_last_d  = 1'b0;
        end
      end
      HDR: begin
        if (accept_s) begin
          state_d   = ADDR;
          tp_data_d = head_s[70:39];
          tp_last_d = 1'b0;
        end else begin
          state_d = HDR;
        end
      end
      ADDR: begin
        if (accept_s) begin
          state_d   = INSN;
          tp_data_d = head_s[102:71];
          tp_last_d = ~has_tval_s;
        end else begin
          state_d = ADDR;
        end
      end
      INSN: begin
        if (accept_s && has_tval_s) begin
          state_d   = TVAL;
          tp_data_d = head_s[31:0];
          tp_last_d = 1'b1;
        end else begin
          done_s = accept_s;
        end
      end
      TVAL: begin
        done_s = accept_s;
      end
      default: begin
        state_d    = IDLE;
        tp_valid_d = 1'b0;
        tp_data_d  = 32'd0;
        tp_last_d  = 1'b0;
      end
    endcase
    if (done_s) begin
      pop_s = 1'b1;
      seq_d = seq_q + 8'd1;
      if ((count_q != CW'(1)) || push_s) begin
        state_d    = HDR;
        snap_s     = 1'b1;
        tp_valid_d = 1'b1;
        tp_data_d  = hdr_beat(next_head_s, drop_cnt_q, seq_q + 8'd1);
        tp_last_d  = 1'b0;
      end else begin
        state_d    = IDLE;
        tp_valid_d = 1'b0;
        tp_data_d  = 32'd0;
        tp_last_d  = 1'b0;
      end
    end else begin
      seq_d = seq_q;
    end
  end

  // Occupancy, pointers, drop accounting and sticky overflow
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (snap_s) begin
      drop_cnt_d = {7'd0, drop_s};
    end else if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO storage; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_entry_s;
    end
  end

  // Sequencer state, registered port outputs and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tp_valid_q <= 1'b0;
      tp_data_q  <= 32'd0;
      tp_last_q  <= 1'b0;
      seq_q      <= 8'd0;
      drop_cnt_q <= 8'd0;
      overflow_q <= 1'b0;
      count_q    <= {CW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
    end else begin
      state_q    <= state_d;
      tp_valid_q <= tp_valid_d;
      tp_data_q  <= tp_data_d;
      tp_last_q  <= tp_last_d;
      seq_q      <= seq_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  assign tp_valid   = tp_valid_q;
  assign tp_data    = tp_data_q;
  assign tp_last    = tp_last_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_el2_trace_port_buf.sv
// Scoreboard bench for el2_trace_port_buf: directed packets push expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_el2_trace_port_buf;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          trace_en;
  logic [103:0]  trace_pkt;
  logic          tp_ready;
  logic          tp_valid;
  logic [31:0]   tp_data;
  logic          tp_last;
  logic          overflow_clr;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q [$];

  el2_trace_port_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .trace_pkt(trace_pkt),
    .tp_ready(tp_ready), .tp_valid(tp_valid), .tp_data(tp_data), .tp_last(tp_last),
    .overflow_clr(overflow_clr), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [103:0] mk_pkt(input logic [31:0] insn, input logic [31:0] addr,
                                          input logic exc, input logic [4:0] ecause,
                                          input logic intr, input logic [31:0] tval);
    mk_pkt = {insn, addr, 1'b1, exc, ecause, intr, tval};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // expected beats of one packet, header built from its fields
  task automatic exp_pkt(input logic [31:0] insn, input logic [31:0] addr, input logic exc,
                         input logic [4:0] ecause, input logic intr, input logic [31:0] tval,
                         input logic [7:0] drop, input logic [7:0] sq);
    logic ht;
    ht = exc | intr;
    exp_q.push_back({1'b0, 8'hA5, drop, ht, exc, intr, ecause, sq});
    exp_q.push_back({1'b0, addr});
    exp_q.push_back({~ht, insn});
    if (ht) exp_q.push_back({1'b1, tval});
  endtask

  // monitor: every accepted beat is compared against the scoreboard head
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && tp_valid && tp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got last=%0b data=%h expected none", tp_last, tp_data);
      end else begin
        e = exp_q.pop_front();
        if ({tp_last, tp_data} !== e) begin
          errors++;
          $display("FAIL beat: got last=%0b data=%h expected last=%0b data=%h",
                   tp_last, tp_data, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic send(input logic [103:0] p);
    trace_pkt = p;
    @(posedge clk); #1;
    trace_pkt = 104'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1; trace_pkt = 104'd0; tp_ready = 1'b0; overflow_clr = 1'b0; trace_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !tp_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("wait_valid", 64'(tp_valid), 64'd1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_count0"}, 64'(fifo_count), 64'd0);
    chk({name, "_idle"}, 64'(tp_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; trace_pkt = 104'd0; tp_ready = 1'b0; overflow_clr = 1'b0; trace_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(tp_valid), 64'd0);
    chk("rst_data", 64'(tp_data), 64'd0);
    chk("rst_last", 64'(tp_last), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);

    // single packet, latency N+2
    do_reset();
    tp_ready = 1'b1;
    exp_q.push_back({1'b0, 32'hA500_0000});
    exp_q.push_back({1'b0, 32'h8000_0010});
    exp_q.push_back({1'b1, 32'h0000_0013});
    send(mk_pkt(32'h0000_0013, 32'h8000_0010, 1'b0, 5'd0, 1'b0, 32'd0));
    chk("lat_n1_valid", 64'(tp_valid), 64'd0);
    chk("lat_n1_count", 64'(fifo_count), 64'd1);
    @(posedge clk); #1;
    chk("lat_n2_valid", 64'(tp_valid), 64'd1);
    chk("lat_n2_hdr", 64'(tp_data), 64'hA500_0000);
    wait_drain("single", 20);

    // exception packet, 4 beats
    do_reset();
    tp_ready = 1'b1;
    exp_q.push_back({1'b0, 32'hA500_C200});
    exp_q.push_back({1'b0, 32'h8000_0020});
    exp_q.push_back({1'b0, 32'h0010_0073});
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    send(mk_pkt(32'h0010_0073, 32'h8000_0020, 1'b1, 5'd2, 1'b0, 32'hDEAD_BEEF));
    wait_drain("exc", 20);

    // backpressure on ADDR beat
    do_reset();
    exp_pkt(32'h0000_0093, 32'h8000_0100, 1'b0, 5'd0, 1'b0, 32'd0, 8'd0, 8'd0);
    send(mk_pkt(32'h0000_0093, 32'h8000_0100, 1'b0, 5'd0, 1'b0, 32'd0));
    wait_valid(10);
    tp_ready = 1'b1;
    @(posedge clk); #1;
    tp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(tp_valid), 64'd1);
      chk("bp_addr", 64'(tp_data), 64'h8000_0100);
    end
    tp_ready = 1'b1;
    wait_drain("bp", 20);

    // overflow: 11 back-to-back packets into a stalled port
    do_reset();
    for (int i = 0; i < 11; i++) begin
      trace_pkt = mk_pkt(32'h0000_0100 + 32'(i), 32'h0000_1000 + 32'(i) * 32'd4,
                         1'b0, 5'd0, 1'b0, 32'd0);
      if (i < 8) exp_pkt(32'h0000_0100 + 32'(i), 32'h0000_1000 + 32'(i) * 32'd4,
                         1'b0, 5'd0, 1'b0, 32'd0, (i == 1) ? 8'd3 : 8'd0, 8'(i));
      @(posedge clk); #1;
    end
    trace_pkt = 104'd0;
    chk("ovf_count", 64'(fifo_count), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_hdr1", 64'(tp_data), 64'hA500_0000);
    // disabled capture while full is not a drop
    trace_en = 1'b0;
    send(mk_pkt(32'h0000_0200, 32'h0000_2000, 1'b0, 5'd0, 1'b0, 32'd0));
    trace_en = 1'b1;
    chk("ovf_en0_count", 64'(fifo_count), 64'd8);
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);
    tp_ready = 1'b1;
    wait_drain("ovf", 100);

    // seq wrap, one packet every 4 cycles
    do_reset();
    tp_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      exp_pkt(32'h0000_0013, 32'h4000_0000 + 32'(i), 1'b0, 5'd0, 1'b0, 32'd0, 8'd0, 8'(i));
      send(mk_pkt(32'h0000_0013, 32'h4000_0000 + 32'(i), 1'b0, 5'd0, 1'b0, 32'd0));
      repeat (3) @(posedge clk);
      #1;
    end
    wait_drain("seq", 50);

    // reset during a TVAL beat
    do_reset();
    exp_q.push_back({1'b0, 32'hA500_C700});
    exp_q.push_back({1'b0, 32'h8000_0300});
    exp_q.push_back({1'b0, 32'h0000_0001});
    send(mk_pkt(32'h0000_0001, 32'h8000_0300, 1'b1, 5'd7, 1'b0, 32'h1234_5678));
    send(mk_pkt(32'h0000_0002, 32'h8000_0304, 1'b0, 5'd0, 1'b0, 32'd0));
    send(mk_pkt(32'h0000_0003, 32'h8000_0308, 1'b0, 5'd0, 1'b0, 32'd0));
    wait_valid(10);
    tp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tp_ready = 1'b0;
    chk("mid_tval", 64'(tp_data), 64'h1234_5678);
    chk("mid_last", 64'(tp_last), 64'd1);
    chk("mid_count", 64'(fifo_count), 64'd3);
    chk("mid_sb_empty", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(tp_valid), 64'd0);
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tp_ready = 1'b1;
    exp_q.push_back({1'b0, 32'hA500_0000});
    exp_q.push_back({1'b0, 32'h8000_0400});
    exp_q.push_back({1'b1, 32'h0000_0013});
    send(mk_pkt(32'h0000_0013, 32'h8000_0400, 1'b0, 5'd0, 1'b0, 32'd0));
    wait_drain("post_rst", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
